// File: rtl/noc_packet_injector.sv
// rtl/noc_packet_injector.sv - Serializes header+payload packets into typed NoC flits on one VC
// A single output register feeds the link; a new flit may load in the same cycle the old one is accepted.
module noc_packet_injector #(
  parameter  int noc_flit_data_width = 32,
  parameter  int noc_flit_type_width = 2,
  parameter  int vchannels           = 3,
  parameter  int max_len             = 8,
  localparam int vc_w                = (vchannels > 1) ? $clog2(vchannels) : 1,
  localparam int len_w               = $clog2(max_len + 1),
  localparam int flit_w              = noc_flit_data_width + noc_flit_type_width
) (
  input  logic                           clk,
  input  logic                           rst_sys,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [vc_w-1:0]                cmd_vchannel,
  input  logic [noc_flit_data_width-1:0] cmd_header,
  input  logic [len_w-1:0]               cmd_len,
  input  logic                           data_valid,
  output logic                           data_ready,
  input  logic [noc_flit_data_width-1:0] data_in,
  output logic [flit_w-1:0]              noc_out_flit,
  output logic [vchannels-1:0]           noc_out_valid,
  input  logic [vchannels-1:0]           noc_out_ready,
  output logic                           busy,
  output logic [15:0]                    pkt_count
);

  localparam logic [noc_flit_type_width-1:0] T_PAYLOAD = noc_flit_type_width'(0);
  localparam logic [noc_flit_type_width-1:0] T_HEADER  = noc_flit_type_width'(1);
  localparam logic [noc_flit_type_width-1:0] T_LAST    = noc_flit_type_width'(2);
  localparam logic [noc_flit_type_width-1:0] T_SINGLE  = noc_flit_type_width'(3);
  localparam logic [vc_w:0]                  VC_LIM    = (vc_w + 1)'(vchannels);
  localparam logic [len_w-1:0]               LEN_MAX   = len_w'(max_len);
  localparam logic [len_w-1:0]               LEN_ONE   = len_w'(1);

  typedef enum logic {ST_IDLE, ST_PAYLOAD} state_t;

  state_t                           r_state;
  state_t                           w_state_next;
  logic [flit_w-1:0]                r_out_flit;
  logic                             r_out_vld;
  logic [vc_w-1:0]                  r_vc;
  logic [len_w-1:0]                 r_remaining;
  logic [15:0]                      r_pkt_count;

  logic                             w_accept;
  logic                             w_free;
  logic                             w_cmd_hs;
  logic                             w_data_hs;
  logic                             w_load;
  logic [flit_w-1:0]                w_load_flit;
  logic [vc_w-1:0]                  w_cmd_vc;
  logic [len_w-1:0]                 w_cmd_len;
  logic [noc_flit_type_width-1:0]   w_out_type;

  assign w_accept   = r_out_vld && noc_out_ready[r_vc];
  assign w_free     = !r_out_vld || w_accept;
  assign w_cmd_vc   = ({1'b0, cmd_vchannel} >= VC_LIM) ? '0 : cmd_vchannel;
  assign w_cmd_len  = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  assign w_out_type = r_out_flit[flit_w-1 -: noc_flit_type_width];

  always_ff @(posedge clk) begin
    if (rst_sys) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    data_ready   = 1'b0;
    w_cmd_hs     = 1'b0;
    w_data_hs    = 1'b0;
    w_load       = 1'b0;
    w_load_flit  = '0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = w_free;
        if (cmd_valid && w_free) begin
          w_cmd_hs    = 1'b1;
          w_load      = 1'b1;
          w_load_flit = {(w_cmd_len == '0) ? T_SINGLE : T_HEADER, cmd_header};
          if (w_cmd_len != '0) w_state_next = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        data_ready = w_free;
        if (data_valid && w_free) begin
          w_data_hs   = 1'b1;
          w_load      = 1'b1;
          w_load_flit = {(r_remaining == LEN_ONE) ? T_LAST : T_PAYLOAD, data_in};
          if (r_remaining == LEN_ONE) w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_sys) begin
      r_out_flit  <= '0;
      r_out_vld   <= 1'b0;
      r_vc        <= '0;
      r_remaining <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_load) begin
        r_out_flit <= w_load_flit;
        r_out_vld  <= 1'b1;
      end else if (w_accept) begin
        r_out_vld  <= 1'b0;
      end
      if (w_cmd_hs) begin
        r_vc        <= w_cmd_vc;
        r_remaining <= w_cmd_len;
      end else if (w_data_hs) begin
        r_remaining <= r_remaining - LEN_ONE;
      end
      // A packet counts as delivered once its closing flit leaves the register.
      if (w_accept && (w_out_type == T_LAST || w_out_type == T_SINGLE))
        r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  always_comb begin
    noc_out_valid = '0;
    for (int i = 0; i < vchannels; i++) begin
      if (r_out_vld && (r_vc == vc_w'(i))) noc_out_valid[i] = 1'b1;
    end
  end

  assign noc_out_flit = r_out_flit;
  assign busy         = (r_state != ST_IDLE) || r_out_vld;
  assign pkt_count    = r_pkt_count;

endmodule
